// File: rtl/cbfp_pkg.sv
// Shared constants and types for the CBFP denormaliser: lane/block geometry,
// exponent format and the exponent-to-shift conversion.
package cbfp_pkg;
    localparam int NCHAN       = 16;
    localparam int BLOCK_SIZE  = 8;
    localparam int NBLOCKS     = NCHAN / BLOCK_SIZE;
    localparam int IDX_W       = 5;
    localparam int IDX_MAX     = 24;
    localparam int TRUNC_VALUE = 13;
    localparam int SHIFT_W     = 6;

    typedef logic [IDX_W-1:0]          idx_t;
    typedef logic signed [SHIFT_W-1:0] shift_t;

    // Illegal exponents above IDX_MAX are clamped before conversion.
    function automatic shift_t idx_to_shift(input idx_t idx);
        idx_t clamped;
        clamped = (idx > idx_t'(IDX_MAX)) ? idx_t'(IDX_MAX) : idx;
        return shift_t'(TRUNC_VALUE) - shift_t'({1'b0, clamped});
    endfunction
endpackage

// File: rtl/cbfp_idx_fifo.sv
// Synchronous index-set FIFO. Occupancy is tracked by its own counter; a pop
// on a full FIFO frees room for a same-cycle push, but nothing bypasses an empty one.
module cbfp_idx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   unf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && !do_push;
    assign unf     = pop && empty;
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/cbfp_denorm.sv
// CBFP denormaliser: pops one exponent set per data beat and rescales each lane
// by (TRUNC_VALUE - idx) with saturation, over a two-register pipeline.
module cbfp_denorm
    import cbfp_pkg::*;
#(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 25,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              idx_valid_in,
    input  logic [NBLOCKS-1:0][IDX_W-1:0]     idx_in,
    output logic                              idx_ready_out,
    input  logic                              valid_in,
    input  logic [NCHAN-1:0][IN_W-1:0]        data_re_in,
    input  logic [NCHAN-1:0][IN_W-1:0]        data_im_in,
    output logic                              valid_out,
    output logic [NCHAN-1:0][OUT_W-1:0]       data_re_out,
    output logic [NCHAN-1:0][OUT_W-1:0]       data_im_out,
    output logic                              sat_out,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_cnt,
    output logic                              err_ovf,
    output logic                              err_unf
);
    localparam int EXT_W = OUT_W + TRUNC_VALUE;

    // Returns {clipped, value}; the working width holds the largest left shift.
    function automatic logic [OUT_W:0] shift_sat(input logic [IN_W-1:0] x, input shift_t s);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] shifted;
        logic [SHIFT_W-1:0]      amt;
        logic                    clip;
        ext     = EXT_W'($signed(x));
        amt     = s[SHIFT_W-1] ? SHIFT_W'(-s) : SHIFT_W'(s);
        shifted = s[SHIFT_W-1] ? (ext >>> amt) : (ext <<< amt);
        clip    = (shifted[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){shifted[EXT_W-1]}});
        if (clip) begin
            return {1'b1, shifted[EXT_W-1], {(OUT_W-1){~shifted[EXT_W-1]}}};
        end
        return {1'b0, shifted[OUT_W-1:0]};
    endfunction

    logic [NBLOCKS*IDX_W-1:0]           fifo_rd;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               fifo_ovf;
    logic                               fifo_unf;
    logic [NBLOCKS-1:0][SHIFT_W-1:0]    s_next;
    logic                               v1_reg;
    logic [NCHAN-1:0][IN_W-1:0]         re1_reg;
    logic [NCHAN-1:0][IN_W-1:0]         im1_reg;
    logic [NBLOCKS-1:0][SHIFT_W-1:0]    s1_reg;
    logic [NCHAN-1:0][OUT_W:0]          re_res;
    logic [NCHAN-1:0][OUT_W:0]          im_res;
    logic [NCHAN-1:0]                   lane_sat;

    cbfp_idx_fifo #(
        .WIDTH (NBLOCKS*IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_idx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (idx_valid_in),
        .wr_data (idx_in),
        .pop     (valid_in),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt),
        .ovf     (fifo_ovf),
        .unf     (fifo_unf)
    );

    assign idx_ready_out = !fifo_full;

    // An underflowing beat passes through unscaled (shift 0).
    generate
        for (genvar gi = 0; gi < NBLOCKS; gi++) begin : g_blk
            assign s_next[gi] = fifo_empty ? '0 : idx_to_shift(idx_t'(fifo_rd[gi*IDX_W +: IDX_W]));
        end
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_lane
            assign re_res[gi]   = shift_sat(re1_reg[gi], shift_t'(s1_reg[gi / BLOCK_SIZE]));
            assign im_res[gi]   = shift_sat(im1_reg[gi], shift_t'(s1_reg[gi / BLOCK_SIZE]));
            assign lane_sat[gi] = re_res[gi][OUT_W] | im_res[gi][OUT_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_reg  <= 1'b0;
            re1_reg <= '0;
            im1_reg <= '0;
            s1_reg  <= '0;
        end else begin
            v1_reg <= valid_in;
            if (valid_in) begin
                re1_reg <= data_re_in;
                im1_reg <= data_im_in;
                s1_reg  <= s_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out   <= 1'b0;
            data_re_out <= '0;
            data_im_out <= '0;
            sat_out     <= 1'b0;
            err_ovf     <= 1'b0;
            err_unf     <= 1'b0;
        end else begin
            valid_out <= v1_reg;
            sat_out   <= v1_reg && (|lane_sat);
            err_ovf   <= err_ovf | fifo_ovf;
            err_unf   <= err_unf | fifo_unf;
            if (v1_reg) begin
                for (int ch = 0; ch < NCHAN; ch++) begin
                    data_re_out[ch] <= re_res[ch][OUT_W-1:0];
                    data_im_out[ch] <= im_res[ch][OUT_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_cbfp_denorm.sv
// Bench for cbfp_denorm: directed scenarios plus random bursts against a
// queue-based exponent model and arithmetic (multiply / floor-divide) scaling.
module tb_cbfp_denorm;
    import cbfp_pkg::*;

    localparam int IN_W   = 12;
    localparam int OUT_W  = 25;
    localparam int OUT_W2 = 20;
    localparam int DEPTH  = 32;

    typedef logic [NCHAN-1:0][IN_W-1:0]   in_lanes_t;
    typedef logic [NCHAN-1:0][OUT_W-1:0]  out_lanes_t;
    typedef logic [NCHAN-1:0][OUT_W2-1:0] out2_lanes_t;

    logic                          clk = 1'b0;
    logic                          rstn = 1'b0;
    logic                          idx_valid_in = 1'b0;
    logic [NBLOCKS-1:0][IDX_W-1:0] idx_in = '0;
    logic                          valid_in = 1'b0;
    in_lanes_t                     data_re_in = '0;
    in_lanes_t                     data_im_in = '0;
    logic                          idx_ready_out, valid_out, sat_out, err_ovf, err_unf;
    out_lanes_t                    data_re_out, data_im_out;
    logic [5:0]                    fifo_cnt;
    logic                          idx_ready_w20, valid_w20, sat_w20, ovf_w20, unf_w20;
    out2_lanes_t                   data_re_w20, data_im_w20;
    logic [5:0]                    cnt_w20;

    int checks = 0;
    int failures = 0;
    int mq0[$];
    int mq1[$];

    cbfp_denorm #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .idx_valid_in(idx_valid_in), .idx_in(idx_in),
        .idx_ready_out(idx_ready_out), .valid_in(valid_in), .data_re_in(data_re_in),
        .data_im_in(data_im_in), .valid_out(valid_out), .data_re_out(data_re_out),
        .data_im_out(data_im_out), .sat_out(sat_out), .fifo_cnt(fifo_cnt),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    cbfp_denorm #(.IN_W(IN_W), .OUT_W(OUT_W2), .FIFO_DEPTH(DEPTH)) dut_w20 (
        .clk(clk), .rstn(rstn), .idx_valid_in(idx_valid_in), .idx_in(idx_in),
        .idx_ready_out(idx_ready_w20), .valid_in(valid_in), .data_re_in(data_re_in),
        .data_im_in(data_im_in), .valid_out(valid_w20), .data_re_out(data_re_w20),
        .data_im_out(data_im_w20), .sat_out(sat_w20), .fifo_cnt(cnt_w20),
        .err_ovf(ovf_w20), .err_unf(unf_w20)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // x scaled by 2^(13-idx); negative shifts round toward minus infinity.
    function automatic longint ref_lane(input int x, input int idx, input int ow, output bit clip);
        int     e, s;
        longint d, v, hi, lo;
        e = (idx > 24) ? 24 : idx;
        s = TRUNC_VALUE - e;
        d = 1;
        repeat ((s >= 0) ? s : -s) d = d * 2;
        if (s >= 0) begin
            v = x * d;
        end else begin
            v = x / d;
            if (x < 0 && (x % d) != 0) v = v - 1;
        end
        hi = 1;
        repeat (ow - 1) hi = hi * 2;
        lo = -hi;
        hi = hi - 1;
        clip = 1'b0;
        if (v > hi) begin v = hi; clip = 1'b1; end
        if (v < lo) begin v = lo; clip = 1'b1; end
        return v;
    endfunction

    function automatic in_lanes_t rand_lanes();
        in_lanes_t r;
        for (int ch = 0; ch < NCHAN; ch++) r[ch] = IN_W'($urandom);
        return r;
    endfunction

    function automatic int rand_idx();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(0, 24));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idx_valid_in = 1'b0;
        valid_in     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        mq0.delete();
        mq1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    // Drives one cycle of inputs and advances the exponent-queue model.
    task automatic drive(input bit push, input int a, input int b, input bit pop,
                         input in_lanes_t re, input in_lanes_t im,
                         output out_lanes_t ere, output out_lanes_t eim,
                         output bit esat, output bit esat2);
        int     pa, pb, idx;
        bit     was_full, pop_ok, c;
        longint v;
        was_full = (mq0.size() == DEPTH);
        pop_ok   = pop && (mq0.size() > 0);
        pa = TRUNC_VALUE;
        pb = TRUNC_VALUE;
        if (pop_ok) begin
            pa = mq0.pop_front();
            pb = mq1.pop_front();
        end
        if (push && (!was_full || pop_ok)) begin
            mq0.push_back(a);
            mq1.push_back(b);
        end
        esat = 1'b0;
        esat2 = 1'b0;
        for (int ch = 0; ch < NCHAN; ch++) begin
            idx = (ch / BLOCK_SIZE == 0) ? pa : pb;
            v = ref_lane(int'($signed(re[ch])), idx, OUT_W, c);
            ere[ch] = v[OUT_W-1:0];
            esat |= c;
            v = ref_lane(int'($signed(im[ch])), idx, OUT_W, c);
            eim[ch] = v[OUT_W-1:0];
            esat |= c;
            v = ref_lane(int'($signed(re[ch])), idx, OUT_W2, c);
            esat2 |= c;
            v = ref_lane(int'($signed(im[ch])), idx, OUT_W2, c);
            esat2 |= c;
        end
        idx_valid_in = push;
        idx_in[0]    = a[IDX_W-1:0];
        idx_in[1]    = b[IDX_W-1:0];
        valid_in     = pop;
        data_re_in   = re;
        data_im_in   = im;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
        checks++; if (idx_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", idx_ready_out); end
        checks++; if (fifo_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
        checks++; if ({err_ovf, err_unf, sat_out} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {err_ovf, err_unf, sat_out}); end
        checks++; if ({data_re_out, data_im_out} !== '0) begin failures++; $display("FAIL reset_data got=nonzero exp=0"); end
        checks++;
        if ({valid_w20, idx_ready_w20, cnt_w20, ovf_w20, unf_w20, sat_w20} !== {2'b01, 6'd0, 3'b000} || {data_re_w20, data_im_w20} !== '0) begin
            failures++; $display("FAIL reset_w20 got=%b exp=01000000000", {valid_w20, idx_ready_w20, cnt_w20, ovf_w20, unf_w20, sat_w20});
        end
    endtask

    task automatic test_passthrough();
        in_lanes_t  re, im;
        out_lanes_t ere, eim;
        bit         esat, es2;
        do_reset();
        re = '0; im = '0;
        re[0] = 12'd100;
        im[0] = 12'hFFB;
        drive(1'b1, 13, 13, 1'b0, '0, '0, ere, eim, esat, es2);
        step();
        checks++; if (fifo_cnt !== 6'd1) begin failures++; $display("FAIL pass_cnt got=%0d exp=1", fifo_cnt); end
        drive(1'b0, 0, 0, 1'b1, re, im, ere, eim, esat, es2);
        step();
        idle();
        step();
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL pass_valid got=%0b exp=1", valid_out); end
        checks++; if (data_re_out[0] !== 25'd100) begin failures++; $display("FAIL pass_re0 got=%0d exp=100", $signed(data_re_out[0])); end
        checks++; if (data_im_out[0] !== 25'h1FFFFFB) begin failures++; $display("FAIL pass_im0 got=%0d exp=-5", $signed(data_im_out[0])); end
        checks++; if (sat_out !== 1'b0) begin failures++; $display("FAIL pass_sat got=%0b exp=0", sat_out); end
        checks++; if (data_re_out !== ere || data_im_out !== eim) begin failures++; $display("FAIL pass_vec got=%h exp=%h", data_re_out, ere); end
        step();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL pass_single got=%0b exp=0", valid_out); end
    endtask

    task automatic test_block_shift();
        in_lanes_t  re, im;
        out_lanes_t ere, eim;
        bit         esat, es2;
        do_reset();
        re = '0; im = '0;
        re[0] = 12'd7;
        re[8] = 12'd7;
        im[8] = 12'hFF9;
        drive(1'b1, 10, 16, 1'b0, '0, '0, ere, eim, esat, es2);
        step();
        drive(1'b0, 0, 0, 1'b1, re, im, ere, eim, esat, es2);
        step();
        idle();
        step();
        checks++; if (data_re_out[0] !== 25'd56) begin failures++; $display("FAIL blk0_shl got=%0d exp=56", $signed(data_re_out[0])); end
        checks++; if (data_re_out[8] !== 25'd0) begin failures++; $display("FAIL blk1_shr got=%0d exp=0", $signed(data_re_out[8])); end
        checks++; if (data_im_out[8] !== 25'h1FFFFFF) begin failures++; $display("FAIL blk1_floor got=%0d exp=-1", $signed(data_im_out[8])); end
        checks++; if (data_re_out !== ere || data_im_out !== eim) begin failures++; $display("FAIL blk_vec got=%h exp=%h", data_im_out, eim); end
    endtask

    task automatic test_saturation();
        in_lanes_t  re, im;
        out_lanes_t ere, eim;
        bit         esat, es2;
        do_reset();
        re = '0; im = '0;
        re[0] = 12'h7FF;
        im[0] = 12'h800;
        drive(1'b1, 0, 0, 1'b0, '0, '0, ere, eim, esat, es2);
        step();
        drive(1'b0, 0, 0, 1'b1, re, im, ere, eim, esat, es2);
        step();
        idle();
        step();
        checks++; if (data_re_out[0] !== 25'd16769024) begin failures++; $display("FAIL sat_re_max got=%0d exp=16769024", $signed(data_re_out[0])); end
        checks++; if (data_im_out[0] !== 25'h1000000) begin failures++; $display("FAIL sat_im_min got=%0d exp=-16777216", $signed(data_im_out[0])); end
        checks++; if (sat_out !== esat) begin failures++; $display("FAIL sat_flag got=%0b exp=%0b", sat_out, esat); end
        checks++; if (data_re_w20[0] !== 20'd524287) begin failures++; $display("FAIL sat20_re got=%0d exp=524287", $signed(data_re_w20[0])); end
        checks++; if (data_im_w20[0] !== 20'h80000) begin failures++; $display("FAIL sat20_im got=%0d exp=-524288", $signed(data_im_w20[0])); end
        checks++; if (sat_w20 !== es2) begin failures++; $display("FAIL sat20_flag got=%0b exp=%0b", sat_w20, es2); end
    endtask

    task automatic test_overflow();
        out_lanes_t ere, eim;
        bit         esat, es2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, rand_idx(), rand_idx(), 1'b0, '0, '0, ere, eim, esat, es2);
            step();
        end
        checks++; if (fifo_cnt !== 6'd32) begin failures++; $display("FAIL ovf_fill_cnt got=%0d exp=32", fifo_cnt); end
        checks++; if (idx_ready_out !== 1'b0 || err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_full_flags got=%b exp=00", {idx_ready_out, err_ovf}); end
        drive(1'b1, 3, 3, 1'b0, '0, '0, ere, eim, esat, es2);
        step();
        checks++; if (err_ovf !== 1'b1 || fifo_cnt !== 6'd32) begin failures++; $display("FAIL ovf_drop got=%0b/%0d exp=1/32", err_ovf, fifo_cnt); end
        drive(1'b1, 7, 20, 1'b1, rand_lanes(), rand_lanes(), ere, eim, esat, es2);
        step();
        idle();
        checks++; if (fifo_cnt !== 6'd32 || idx_ready_out !== 1'b0) begin failures++; $display("FAIL ovf_pushpop got=%0d exp=32", fifo_cnt); end
        step();
        checks++; if (valid_out !== 1'b1 || data_re_out !== ere || data_im_out !== eim || sat_out !== esat) begin
            failures++; $display("FAIL ovf_pop_data got=%h exp=%h", data_re_out, ere);
        end
        checks++; if (err_unf !== 1'b0) begin failures++; $display("FAIL ovf_no_unf got=%0b exp=0", err_unf); end
    endtask

    task automatic test_underflow();
        in_lanes_t  re;
        out_lanes_t ere, eim, pre, pim;
        bit         esat, es2, psat;
        do_reset();
        re = rand_lanes();
        drive(1'b1, 5, 5, 1'b1, re, rand_lanes(), pre, pim, psat, es2);
        step();
        checks++; if (err_unf !== 1'b1 || fifo_cnt !== 6'd1) begin failures++; $display("FAIL unf_flag_cnt got=%0b/%0d exp=1/1", err_unf, fifo_cnt); end
        drive(1'b0, 0, 0, 1'b1, rand_lanes(), rand_lanes(), ere, eim, esat, es2);
        step();
        checks++; if (data_re_out[3] !== OUT_W'(int'($signed(re[3])))) begin failures++; $display("FAIL unf_sext got=%0d exp=%0d", $signed(data_re_out[3]), $signed(re[3])); end
        checks++; if (data_re_out !== pre || data_im_out !== pim || sat_out !== psat) begin failures++; $display("FAIL unf_vec got=%h exp=%h", data_re_out, pre); end
        idle();
        step();
        checks++; if (data_re_out !== ere || data_im_out !== eim || sat_out !== esat) begin failures++; $display("FAIL unf_next got=%h exp=%h", data_re_out, ere); end
        checks++; if (fifo_cnt !== 6'd0 || err_unf !== 1'b1) begin failures++; $display("FAIL unf_after got=%0d/%0b exp=0/1", fifo_cnt, err_unf); end
    endtask

    // Continuous beats; an abort_at >= 0 asserts reset mid-burst at that cycle.
    task automatic test_back_to_back(input int nbeats, input int abort_at);
        int         lag;
        bit         push, pop, esat, es2, psat, pvalid;
        out_lanes_t ere, eim, pre, pim;
        do_reset();
        lag = $urandom_range(2, 20);
        pvalid = 1'b0; psat = 1'b0; pre = '0; pim = '0;
        for (int c = 0; c < nbeats + lag + 1; c++) begin
            push = (c < nbeats);
            pop  = (c >= lag) && (c < lag + nbeats);
            drive(push, rand_idx(), rand_idx(), pop, rand_lanes(), rand_lanes(), ere, eim, esat, es2);
            step();
            checks++; if (valid_out !== pvalid) begin failures++; $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, valid_out, pvalid); end
            if (pvalid) begin
                checks++; if (data_re_out !== pre) begin failures++; $display("FAIL b2b_re c=%0d got=%h exp=%h", c, data_re_out, pre); end
                checks++; if (data_im_out !== pim) begin failures++; $display("FAIL b2b_im c=%0d got=%h exp=%h", c, data_im_out, pim); end
                checks++; if (sat_out !== psat) begin failures++; $display("FAIL b2b_sat c=%0d got=%0b exp=%0b", c, sat_out, psat); end
            end
            pvalid = pop; pre = ere; pim = eim; psat = esat;
            if (c == abort_at) begin
                #2 rstn = 1'b0;
                #1;
                checks++; if (valid_out !== 1'b0 || fifo_cnt !== 6'd0 || idx_ready_out !== 1'b1) begin
                    failures++; $display("FAIL midrst got=%0b/%0d exp=0/0", valid_out, fifo_cnt);
                end
                idle();
                mq0.delete();
                mq1.delete();
                @(negedge clk);
                rstn = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    step();
                    checks++; if (valid_out !== 1'b0 || fifo_cnt !== 6'd0) begin failures++; $display("FAIL midrst_stale k=%0d got=%0b/%0d exp=0/0", k, valid_out, fifo_cnt); end
                end
                return;
            end
        end
        idle();
        checks++; if (fifo_cnt !== 6'd0 || err_unf !== 1'b0 || err_ovf !== 1'b0) begin
            failures++; $display("FAIL b2b_end got=%0d/%0b/%0b exp=0/0/0", fifo_cnt, err_unf, err_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_block_shift();
        test_saturation();
        test_overflow();
        test_underflow();
        test_back_to_back(100, -1);
        test_back_to_back(60, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
